// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter for a single shared memory.
//
// Each transaction is IDLE (arbitrate and latch the command), ACCESS (drive
// the memory for one cycle), then RESP (single-cycle ack to the owner).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   m0_* / m1_*         requester 0 (CPU) and requester 1 (loader/DMA):
//                       req, wr, addr, wdata in; ack pulse, registered rdata out
//   mem_addr/wdata/wr   shared memory command (addr/wdata hold outside ACCESS)
//   mem_rdata           combinational read data from the memory
//   busy                high whenever the FSM is not IDLE
//   owner               ID of the latched requester
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic lat_wr;      // latched write/read select of the owner
  logic last_grant;  // requester granted most recently (reset 1: m0 wins first tie)
  logic grant_id;    // requester that would win arbitration this cycle
  logic take;        // accept a new command in IDLE

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // mem_wr and the acks are decoded from the state register so that an
  // asynchronous reset drops them immediately, even mid-ACCESS.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    mem_wr    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    busy      = 1'b1;
    // Tie goes to whoever was not granted last; otherwise the lone requester.
    grant_id  = (m0_req && m1_req) ? ~last_grant : m1_req;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (m0_req || m1_req) begin
          take      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_wr    = lat_wr;
        state_nxt = RESP;
      end
      RESP: begin
        m0_ack    = ~owner;
        m1_ack    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= 1'b0;
      lat_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      last_grant <= 1'b1;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      if (take) begin
        owner <= grant_id;
        if (grant_id) begin
          lat_wr    <= m1_wr;
          mem_addr  <= m1_addr;
          mem_wdata <= m1_wdata;
        end else begin
          lat_wr    <= m0_wr;
          mem_addr  <= m0_addr;
          mem_wdata <= m0_wdata;
        end
      end
      // End of ACCESS == entry to RESP: record the grant, capture read data.
      if (state == ACCESS) begin
        last_grant <= owner;
        if (!lat_wr) begin
          if (owner) m1_rdata <= mem_rdata;
          else       m0_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small
// behavioural memory. Inputs are driven and outputs sampled on the falling
// edge, so every check sits half a cycle away from the active edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        busy, owner;

  logic [15:0] tb_mem [0:255];
  logic        mem_init = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: combinational read, write on rising edge; preloaded on first edge.
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 16'h0000;
      tb_mem[8'h40] <= 16'h1234;
      tb_mem[8'h30] <= 16'h5555;
      mem_init <= 1'b1;
    end else if (mem_wr) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit who, input logic req, input logic wr,
                       input logic [7:0] addr, input logic [15:0] wd);
    if (who) begin
      m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wd;
    end else begin
      m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wd;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_wr"},    32'(mem_wr),    32'h0);
    check({tag, "_m0_ack"},    32'(m0_ack),    32'h0);
    check({tag, "_m1_ack"},    32'(m1_ack),    32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
    check({tag, "_owner"},     32'(owner),     32'h0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_m0_rdata"},  32'(m0_rdata),  32'h0);
    check({tag, "_m1_rdata"},  32'(m1_rdata),  32'h0);
  endtask

  // Call on a falling edge with FSM idle: one full transaction, ack two
  // cycles after the sampling edge, req dropped in the ack cycle.
  task automatic run_txn(input string tag, input bit who, input logic wr,
                         input logic [7:0] addr, input logic [15:0] wd);
    drive(who, 1'b1, wr, addr, wd);
    @(negedge clk);  // ACCESS
    check({tag, "_acc_mem_wr"}, 32'(mem_wr),   32'(wr));
    check({tag, "_acc_addr"},   32'(mem_addr), 32'(addr));
    check({tag, "_acc_owner"},  32'(owner),    32'(who));
    check({tag, "_acc_busy"},   32'(busy),     32'h1);
    check({tag, "_acc_acks"},   32'({m1_ack, m0_ack}), 32'h0);
    if (wr) check({tag, "_acc_wdata"}, 32'(mem_wdata), 32'(wd));
    @(negedge clk);  // RESP
    check({tag, "_resp_m0_ack"}, 32'(m0_ack), 32'(!who));
    check({tag, "_resp_m1_ack"}, 32'(m1_ack), 32'(who));
    check({tag, "_resp_mem_wr"}, 32'(mem_wr), 32'h0);
    drive(who, 1'b0, wr, addr, wd);
    @(negedge clk);  // IDLE
    check({tag, "_idle_acks"},  32'({m1_ack, m0_ack}), 32'h0);
    check({tag, "_idle_busy"},  32'(busy),     32'h0);
    check({tag, "_idle_maddr"}, 32'(mem_addr), 32'(addr));
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    @(negedge clk);
    check("rst0_idle_busy", 32'(busy), 32'h0);

    // Lone write m0 -> 0x10 = BEEF
    run_txn("wr10", 1'b0, 1'b1, 8'h10, 16'hBEEF);
    check("wr10_mem", 32'(tb_mem[8'h10]), 32'hBEEF);

    // m0 reads preloaded 0x40
    run_txn("rd40", 1'b0, 1'b0, 8'h40, 16'h0000);
    check("rd40_m0_rdata", 32'(m0_rdata), 32'h1234);

    // m1 reads back 0x10; m0_rdata must not move
    run_txn("rd10", 1'b1, 1'b0, 8'h10, 16'h0000);
    check("rd10_m1_rdata", 32'(m1_rdata), 32'hBEEF);
    check("rd10_m0_rdata", 32'(m0_rdata), 32'h1234);

    // Command changes after grant are ignored
    drive(1'b0, 1'b1, 1'b1, 8'h20, 16'h1111);
    @(negedge clk);  // ACCESS
    m0_addr = 8'h30;
    #1;
    check("stab_addr",   32'(mem_addr), 32'h20);
    check("stab_mem_wr", 32'(mem_wr),   32'h1);
    @(negedge clk);  // RESP
    check("stab_ack", 32'(m0_ack), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    check("stab_mem20", 32'(tb_mem[8'h20]), 32'h1111);
    check("stab_mem30", 32'(tb_mem[8'h30]), 32'h5555);

    // m1 pulses req during m0's ACCESS and drops it before IDLE
    drive(1'b0, 1'b1, 1'b1, 8'h60, 16'h2222);
    @(negedge clk);  // ACCESS (m0)
    drive(1'b1, 1'b1, 1'b1, 8'h70, 16'h3333);
    @(negedge clk);  // RESP (m0)
    check("drop_m0_ack", 32'(m0_ack), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drop_m1_ack", 32'(m1_ack), 32'h0);
      check("drop_busy",   32'(busy),   32'h0);
    end
    check("drop_mem70", 32'(tb_mem[8'h70]), 32'h0);
    check("drop_mem60", 32'(tb_mem[8'h60]), 32'h2222);

    // Tie straight out of reset: m0, m1, m0, m1, acks 3 cycles apart
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst1");
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h40, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("tie_m0_ack", 32'(m0_ack), 32'((i % 3 == 2) && ((i / 3) % 2 == 0)));
      check("tie_m1_ack", 32'(m1_ack), 32'((i % 3 == 2) && ((i / 3) % 2 == 1)));
      if (i % 3 == 1) check("tie_owner", 32'(owner), 32'((i / 3) % 2));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    check("tie_m0_rdata", 32'(m0_rdata), 32'h1234);
    check("tie_m1_rdata", 32'(m1_rdata), 32'hBEEF);
    @(negedge clk);

    // Reset during ACCESS of a write
    drive(1'b0, 1'b1, 1'b1, 8'h50, 16'hAAAA);
    @(negedge clk);  // ACCESS
    check("mrst_pre_mem_wr", 32'(mem_wr), 32'h1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("mrst");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    check("mrst_m0_ack", 32'(m0_ack), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mrst_post_ack", 32'({m1_ack, m0_ack}), 32'h0);
    end
    check("mrst_mem50", 32'(tb_mem[8'h50]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the memory address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 m0_req, m1_req  input  1  SHALL each be the access request of requester 0 (CPU) and requester 1 (loader/DMA).
REQ-006 m0_wr, m1_wr  input  1  SHALL each select a write (1) or a read (0).
REQ-007 m0_addr, m1_addr  input  ADDR_WIDTH  SHALL each carry the access address.
REQ-008 m0_wdata, m1_wdata  input  DATA_WIDTH  SHALL each carry the write data.
REQ-009 m0_ack, m1_ack  output  1  SHALL each signal transaction completion, as a single-cycle pulse.
REQ-010 m0_rdata, m1_rdata  output  DATA_WIDTH  SHALL each be a registered read-data return.
REQ-011 mem_addr  output  ADDR_WIDTH, mem_wdata  output  DATA_WIDTH, and mem_wr  output  1 SHALL drive the shared memory.
REQ-012 mem_rdata  input  DATA_WIDTH  SHALL be the memory's combinational read data.
REQ-013 busy  output  1  SHALL be high whenever the FSM is not in IDLE; owner  output  1  SHALL give the ID of the latched requester.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCESS and RESP, and SHALL follow the path IDLE->ACCESS->RESP->IDLE with no other transitions.
REQ-015 In IDLE with no request present, the FSM SHALL remain in IDLE.
REQ-016 In IDLE with at least one request present, the block SHALL grant one requester, latch that requester's wr, addr and wdata and its ID into owner, and enter ACCESS.
REQ-017 Arbitration SHALL be round-robin:
- single requester: that requester wins;
- both requesting: the requester not granted last (last_grant) wins.
REQ-018 last_grant SHALL update on entry to RESP.
REQ-019 In ACCESS:
- mem_addr and mem_wdata SHALL equal the latched values;
- mem_wr SHALL equal the latched wr for exactly this one cycle.
REQ-020 mem_wr SHALL be 0 in every state other than ACCESS.
REQ-021 mem_addr and mem_wdata SHALL hold their last latched values outside ACCESS.
REQ-022 For a read, mem_rdata SHALL be captured at the end of ACCESS into the owner's rdata register; the other requester's rdata register SHALL be unchanged.
REQ-023 For a write, the owner's rdata register SHALL be unchanged.
REQ-024 In RESP, the owner's ack SHALL be 1 for exactly one cycle and the other ack SHALL be 0.
REQ-025 rdata SHALL be valid in the ack cycle and SHALL hold until that requester's next read completes.
REQ-026 Latency SHALL be: request sampled in IDLE at edge N, ACCESS in cycle N+1, ack in cycle N+2.
REQ-027 Throughput SHALL be at most one transaction per 3 cycles.
REQ-028 A requester SHALL hold req and its command stable until its ack.
REQ-029 Command changes after the grant SHALL be ignored, because the latched values are used.
REQ-030 A req dropped before the grant SHALL produce no transaction.
REQ-031 A req still high in the cycle after its ack SHALL be arbitrated as a new transaction.
REQ-032 No requester SHALL wait more than one transaction of the other requester while continuously requesting (no starvation).

Reset
REQ-033 While rst=0, asynchronously:
- the FSM SHALL be IDLE;
- mem_wr, m0_ack, m1_ack, busy and owner SHALL be 0;
- mem_addr, mem_wdata, m0_rdata and m1_rdata SHALL be 0;
- last_grant SHALL be 1, so requester 0 wins the first tie.
REQ-034 Reset asserted during ACCESS SHALL drop mem_wr immediately and SHALL abort the transaction with no ack.
REQ-035 After rst rises, the first arbitration SHALL occur at the next rising edge at which the FSM is in IDLE.

Verification
REQ-036 The bench SHALL cover a lone write: m0 writes addr 0x10, data 0xBEEF -> mem_wr=1 for one cycle with mem_addr=0x10, then m0_ack one cycle later, with m1_ack=0 throughout.
REQ-037 The bench SHALL cover a read-back: with 0xBEEF preloaded at 0x10, m1 reads 0x10 -> m1_ack two cycles after the sampled req, m1_rdata=0xBEEF, and m0_rdata unchanged.
REQ-038 The bench SHALL cover a tie after reset: m0 and m1 both request from the first cycle -> grant order m0, m1, m0, m1 with acks 3 cycles apart.
REQ-039 The bench SHALL cover a mid-ACCESS reset: rst driven low during ACCESS of a write -> mem_wr falls without a clock edge, no ack is issued, and all outputs read 0.
REQ-040 The bench SHALL cover command stability after grant: m0 changes addr from 0x20 to 0x30 in the ACCESS cycle -> mem_addr=0x20 and the memory at 0x30 is untouched.
REQ-041 The bench SHALL cover a dropped request: m1 pulses req while m0 is in ACCESS and drops it before IDLE -> no m1 transaction and no m1_ack.
